// File: rtl/mul_seq_m.sv
// mul_seq_m: multicycle 4x4 unsigned shift-and-add multiplier controller.
// Wraps an external adder (adder_m): drives its operands adout0/bdout0 and
// folds its result tadd back into the {hi,lo} partial-product register.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, is held with stable data until that edge.
// Optional feature: define MUL_ZERO_BYPASS_EN to skip CALC when either
// operand is zero (product 0 is presented right after the accept edge).
module mul_seq_m #(
  parameter int OPW  = 4,
  parameter int CNTW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    a_in,
  input  logic [OPW-1:0]    b_in,
  output logic [OPW-1:0]    adout0,
  output logic [OPW-1:0]    bdout0,
  input  logic [2*OPW-1:0]  tadd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OPW-1:0]  product,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [OPW-1:0]  mcand;
  logic [OPW-1:0]  hi;
  logic [OPW-1:0]  lo;
  logic [CNTW-1:0] cnt;
  logic            accept;
  logic            last_iter;
  logic            zero_op;

  // Only the carry and sum bits of the adder are meaningful; upper bits are don't-care.
  logic unused_tadd;
  assign unused_tadd = ^tadd[2*OPW-1:OPW+1];

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (cnt == CNTW'(OPW - 1));

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (a_in == '0) || (b_in == '0);
`else
  assign zero_op = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake/adder outputs decoded from state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    adout0    = '0;
    bdout0    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        busy   = 1'b1;
        adout0 = hi;
        bdout0 = lo[0] ? mcand : '0;
        if (last_iter) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift-and-add iterations, product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        mcand <= a_in;
        hi    <= '0;
        cnt   <= '0;
        if (zero_op) begin
          lo      <= '0;
          product <= '0;
        end else begin
          lo <= b_in;
        end
      end else if (state == CALC) begin
        // Adder carry lands in hi[MSB]; the bit shifted out of hi enters lo.
        hi  <= tadd[OPW:1];
        lo  <= {tadd[0], lo[OPW-1:1]};
        cnt <= cnt + CNTW'(1);
        if (last_iter) begin
          product <= {tadd[OPW:0], lo[OPW-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_m.sv
// tb_mul_seq_m: scoreboard bench for mul_seq_m with a behavioural adder.
module tb_mul_seq_m;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] adout0;
  logic [3:0] bdout0;
  logic [7:0] tadd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_rdy = 0;
  bit seen_valid = 0;
  bit carry_seen = 0;

  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         lat_q[$];

  mul_seq_m #(.OPW(4), .CNTW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
    .adout0(adout0), .bdout0(bdout0), .tadd(tadd),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  // Stand-in for adder_m: plain unsigned addition of the two nibbles.
  assign tadd = {4'b0000, adout0} + {4'b0000, bdout0};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Cycles from the accept edge to the edge after which out_valid is high.
  function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 4'd0 || b == 4'd0) return 0;
`endif
    return 4;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(8'(int'(a) * int'(b)));
      acc_q.push_back(cyc + 1);
      lat_q.push_back(exp_lat(a, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_in = 4'($urandom_range(0, 15));
      b_in = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n = n + 1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    out_ready = v;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    seen_valid = 0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_product", int'(product), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_adder_ops", int'({adout0, bdout0}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Randomised downstream readiness, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && tadd[4]) carry_seen = 1;
      if (!busy) check("idle_adder_ops", int'({adout0, bdout0}), 0);
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        if (acc_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_product", 1, 0);
        end else begin
          check("product", int'(product), int'(exp_q.pop_front()));
        end
        seen_valid = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    a_in = 4'd0;
    b_in = 4'd0;
    out_ready = 1'b0;

    // Reset and quiet idle period.
    do_reset();
    repeat (5) @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);

    // 0xD * 0xB = 0x8F; first CALC cycle shows hi=0 and multiplicand selected.
    set_ready(1'b1);
    issue(4'hD, 4'hB);
    @(negedge clk);
    check("calc0_adout0", int'(adout0), 0);
    check("calc0_bdout0", int'(bdout0), 4'hD);
    check("calc_in_ready", int'(in_ready), 0);
    drain();

    // 0xF * 0xF = 0xE1 exercises the adder carry.
    carry_seen = 0;
    issue(4'hF, 4'hF);
    drain();
    check("carry_seen", int'(carry_seen), 1);

    // Backpressure: product held while out_ready is low.
    set_ready(1'b0);
    issue(4'h2, 4'h3);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_product", int'(product), 8'h06);
      check("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    @(negedge clk);
    check("bp_back_idle", int'(in_ready), 1);
    check("bp_valid_drop", int'(out_valid), 0);
    check("bp_product_kept", int'(product), 8'h06);

    // Reset after two CALC iterations discards the operation.
    set_ready(1'b1);
    issue(4'h5, 4'h7);
    @(posedge clk);
    @(posedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", int'(out_valid), 0);
      check("post_rst_product", int'(product), 0);
    end
    issue(4'h3, 4'h4);
    drain();

    // Zero operand: latency depends on the bypass option, product is 0.
    issue(4'h0, 4'h9);
    drain();
    issue(4'h7, 4'h0);
    drain();

    // Randomised operands with random downstream backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    rand_rdy = 0;
    set_ready(1'b0);
    repeat (3) @(negedge clk);
    check("final_idle", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
